// File: rtl/soc_pkg.sv
// Shared definitions for the SPI memory controller.
// Holds the controller state encoding, the default SPI opcodes, the number of
// bytes per memory transaction, and helpers that map a byte index onto the
// byte value and the controller state that sends it.
package soc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_M,
        ADDR_L,
        DATA,
        GAP,
        ACK
    } mem_state_t;

    localparam logic [7:0]  SPI_CMD_READ  = 8'h03;
    localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
    localparam int unsigned SPI_TXN_BYTES = 5;
    localparam logic [2:0]  SPI_LAST_BYTE = 3'(SPI_TXN_BYTES - 1);

    // Byte order on MOSI: opcode, upper address, addr[15:8], addr[7:0], payload.
    function automatic logic [7:0] spi_txn_byte(
        input logic [2:0]  idx,
        input logic [7:0]  opcode,
        input logic [7:0]  addr_upper,
        input logic [15:0] addr,
        input logic [7:0]  payload
    );
        case (idx)
            3'd0:    return opcode;
            3'd1:    return addr_upper;
            3'd2:    return addr[15:8];
            3'd3:    return addr[7:0];
            default: return payload;
        endcase
    endfunction

    // The last two bytes (low address and payload) share the DATA state.
    function automatic mem_state_t state_for_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD;
            3'd1:    return ADDR_M;
            3'd2:    return ADDR_L;
            default: return DATA;
        endcase
    endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// CPU-side bus of the SPI memory controller.
//   bus_address  16  CPU bus address
//   bus_data_wr   8  CPU write data
//   bus_read      1  read request, level
//   bus_write     1  write request, level
//   bus_data_rd   8  read data returned to the CPU
//   bus_done      1  transaction complete (CPU wait = !bus_done)
// master: the CPU side; slave: the controller side.
interface spi_mem_ctrl_if;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_wr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_data_rd;
    logic        bus_done;

    modport master (
        output bus_address, bus_data_wr, bus_read, bus_write,
        input  bus_data_rd, bus_done
    );

    modport slave (
        input  bus_address, bus_data_wr, bus_read, bus_write,
        output bus_data_rd, bus_done
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: turns a CPU read/write request into a 5-byte SPI
// memory transaction driven through a byte-level spi_core handshake.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   bus         CPU bus (spi_mem_ctrl_if.slave)
//   spi_cs_n    SPI memory chip select, active-low
//   byte_tx     byte presented to spi_core
//   byte_valid  byte_tx is valid (spi_core have_data)
//   byte_rx     byte received by spi_core
//   byte_done   spi_core one-cycle pulse per completed byte
module spi_mem_ctrl
    import soc_pkg::*;
#(
    parameter logic [7:0]  CMD_READ   = SPI_CMD_READ,
    parameter logic [7:0]  CMD_WRITE  = SPI_CMD_WRITE,
    parameter logic [7:0]  ADDR_UPPER = 8'h00,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_mem_ctrl_if.slave bus,
    output logic          spi_cs_n,
    output logic [7:0]    byte_tx,
    output logic          byte_valid,
    input  logic [7:0]    byte_rx,
    input  logic          byte_done
);

    localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

    mem_state_t  state_reg, state_next;
    logic        op_read_reg, op_read_next;
    logic [15:0] addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic [3:0]  gap_cnt_reg, gap_cnt_next;
    logic        byte_valid_reg, byte_valid_next;
    logic [7:0]  byte_tx_reg, byte_tx_next;
    logic        cs_n_reg, cs_n_next;
    logic        done_reg, done_next;
    logic [7:0]  rd_data_reg, rd_data_next;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_read_reg    <= 1'b0;
            addr_reg       <= 16'h0000;
            wdata_reg      <= 8'h00;
            byte_cnt_reg   <= 3'd0;
            gap_cnt_reg    <= 4'd0;
            byte_valid_reg <= 1'b0;
            byte_tx_reg    <= 8'h00;
            cs_n_reg       <= 1'b1;
            done_reg       <= 1'b0;
            rd_data_reg    <= 8'h00;
        end else begin
            op_read_reg    <= op_read_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            byte_cnt_reg   <= byte_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            byte_valid_reg <= byte_valid_next;
            byte_tx_reg    <= byte_tx_next;
            cs_n_reg       <= cs_n_next;
            done_reg       <= done_next;
            rd_data_reg    <= rd_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        op_read_next    = op_read_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        byte_cnt_next   = byte_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        byte_valid_next = byte_valid_reg;
        byte_tx_next    = byte_tx_reg;
        cs_n_next       = cs_n_reg;
        done_next       = done_reg;
        rd_data_next    = rd_data_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.bus_read || bus.bus_write) begin
                    // A simultaneous read and write request resolves to a read.
                    op_read_next  = bus.bus_read;
                    addr_next     = bus.bus_address;
                    wdata_next    = bus.bus_data_wr;
                    byte_cnt_next = 3'd0;
                    cs_n_next     = 1'b0;
                    state_next    = CMD;
                end
            end

            CMD, ADDR_M, ADDR_L, DATA: begin
                if (!byte_valid_reg) begin
                    // One idle cycle between bytes, then present the next one.
                    byte_valid_next = 1'b1;
                    byte_tx_next    = spi_txn_byte(byte_cnt_reg,
                                                   op_read_reg ? CMD_READ : CMD_WRITE,
                                                   ADDR_UPPER, addr_reg,
                                                   op_read_reg ? 8'h00 : wdata_reg);
                end else if (byte_done) begin
                    byte_valid_next = 1'b0;
                    if (byte_cnt_reg == SPI_LAST_BYTE) begin
                        if (op_read_reg) rd_data_next = byte_rx;
                        cs_n_next    = 1'b1;
                        gap_cnt_next = 4'd0;
                        state_next   = GAP;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                        state_next    = state_for_byte(byte_cnt_reg + 3'd1);
                    end
                end
            end

            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    done_next  = 1'b1;
                    state_next = ACK;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end

            ACK: begin
                // Hold completion until the CPU releases both requests, so a
                // lingering request cannot start a second transaction.
                if (!bus.bus_read && !bus.bus_write) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign spi_cs_n        = cs_n_reg;
    assign byte_tx         = byte_tx_reg;
    assign byte_valid      = byte_valid_reg;
    assign bus.bus_done    = done_reg;
    assign bus.bus_data_rd = rd_data_reg;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: a CPU driver, a randomized spi_core
// responder, a reference model that queues the expected MOSI bytes and read
// data per request, and a monitor that checks whatever the DUT presents.
module tb_spi_mem_ctrl;

    localparam int CS_GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs_n;
    logic [7:0] byte_tx;
    logic       byte_valid;
    logic [7:0] byte_rx;
    logic       byte_done;

    spi_mem_ctrl_if bus_if ();

    spi_mem_ctrl #(
        .CMD_READ   (8'h03),
        .CMD_WRITE  (8'h02),
        .ADDR_UPPER (8'h00),
        .CS_GAP     (CS_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .spi_cs_n   (spi_cs_n),
        .byte_tx    (byte_tx),
        .byte_valid (byte_valid),
        .byte_rx    (byte_rx),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int mon_bytes = 0;
    int txn_no = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] exp_rd[$];
    logic [7:0] model_rd = 8'h00;
    logic [7:0] rx5 = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference model: the memory transaction seen from outside.
    task automatic model_issue(input bit is_read, input logic [15:0] a, input logic [7:0] d);
        exp_bytes.push_back(is_read ? 8'h03 : 8'h02);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(a[15:8]);
        exp_bytes.push_back(a[7:0]);
        exp_bytes.push_back(is_read ? 8'h00 : d);
        if (is_read) model_rd = rx5;
        exp_rd.push_back(model_rd);
    endtask

    // spi_core model: random latency per byte, byte 5 returns rx5, and
    // spurious byte_done pulses while byte_valid is low.
    initial begin
        int resp_idx;
        int resp_wait;
        resp_idx  = 0;
        resp_wait = -1;
        byte_done = 1'b0;
        byte_rx   = 8'h00;
        forever begin
            @(negedge clk);
            byte_done = 1'b0;
            if (rst) begin
                resp_idx  = 0;
                resp_wait = -1;
            end else begin
                if (resp_wait < 0 && byte_valid) resp_wait = int'($urandom_range(0, 3));
                if (resp_wait == 0) begin
                    byte_done = 1'b1;
                    byte_rx   = (resp_idx == 4) ? rx5 : 8'($urandom);
                    resp_idx  = (resp_idx + 1) % 5;
                    resp_wait = -1;
                end else if (resp_wait > 0) begin
                    resp_wait--;
                end else if ($urandom_range(0, 7) == 0) begin
                    byte_done = 1'b1;
                    byte_rx   = 8'($urandom);
                end
            end
        end
    end

    // Monitor: samples 2 time units after the falling edge.
    initial begin
        int  pos, gap_run, cs_run;
        bit  measuring, prev_done, pend_low, pend_high;
        pos = 0; gap_run = 0; cs_run = 100;
        measuring = 0; prev_done = 0; pend_low = 0; pend_high = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pos = 0; measuring = 0; prev_done = 0;
                pend_low = 0; pend_high = 0; cs_run = 100;
            end else begin
                if (pend_high) begin
                    check("valid_reassert", 32'(byte_valid), 32'd1);
                    pend_high = 0;
                end
                if (pend_low) begin
                    check("valid_gap", 32'(byte_valid), 32'd0);
                    pend_low = 0;
                    if (pos != 0) pend_high = 1;
                end
                if (byte_valid && byte_done) begin
                    mon_bytes++;
                    check("cs_active", 32'(spi_cs_n), 32'd0);
                    if (exp_bytes.size() == 0) fail_now("extra_byte", $sformatf("unexpected byte %0h", byte_tx));
                    else check("mosi_byte", 32'(byte_tx), 32'(exp_bytes.pop_front()));
                    pos      = (pos + 1) % 5;
                    pend_low = 1;
                    if (pos == 0) begin
                        measuring = 1;
                        gap_run   = 0;
                    end
                end else if (measuring && !bus_if.bus_done) begin
                    gap_run++;
                end
                if (bus_if.bus_done && !prev_done) begin
                    if (exp_rd.size() == 0) fail_now("spurious_done", "bus_done with no transaction pending");
                    else check("bus_data_rd", 32'(bus_if.bus_data_rd), 32'(exp_rd.pop_front()));
                    check("cs_gap_cycles", 32'(gap_run), 32'(CS_GAP));
                    measuring = 0;
                end
                prev_done = bus_if.bus_done;
                if (spi_cs_n) begin
                    cs_run++;
                end else begin
                    if (cs_run > 0) begin
                        checks++;
                        if (cs_run >= CS_GAP) passes++;
                        else $display("FAIL cs_high_min: got %0d cycles, expected >= %0d", cs_run, CS_GAP);
                    end
                    cs_run = 0;
                end
            end
        end
    end

    task automatic cpu_txn(input bit rd_req, input bit wr_req, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] rx, input int hold,
                           input bit scramble);
        int  t;
        bit  is_read;
        is_read = rd_req;
        @(negedge clk);
        rx5 = rx;
        model_issue(is_read, a, d);
        bus_if.bus_read    = rd_req;
        bus_if.bus_write   = wr_req;
        bus_if.bus_address = a;
        bus_if.bus_data_wr = d;
        @(negedge clk);
        t = 0;
        while (!bus_if.bus_done && t < 500) begin
            if (scramble) begin
                bus_if.bus_address = 16'($urandom);
                bus_if.bus_data_wr = 8'($urandom);
                if (is_read) bus_if.bus_write = 1'($urandom);
                else         bus_if.bus_read  = 1'($urandom);
            end
            @(negedge clk);
            t++;
        end
        if (!bus_if.bus_done) begin
            fail_now("done_timeout", $sformatf("no bus_done for addr %h", a));
            exp_bytes.delete();
            exp_rd.delete();
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("done_hold", 32'(bus_if.bus_done), 32'd1);
            end
        end
        bus_if.bus_read  = 1'b0;
        bus_if.bus_write = 1'b0;
        @(negedge clk);
        check("done_drop", 32'(bus_if.bus_done), 32'd0);
        txn_no++;
        $display("txn %0d: %s addr=%h wdata=%h hold=%0d rd_data=%h", txn_no,
                 is_read ? "READ " : "WRITE", a, d, hold, bus_if.bus_data_rd);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base;
        rst = 1'b1;
        bus_if.bus_read    = 1'b0;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = 16'h0000;
        bus_if.bus_data_wr = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_tx", 32'(byte_tx), 32'h00);
        check("rst_bus_done", 32'(bus_if.bus_done), 32'd0);
        check("rst_bus_data_rd", 32'(bus_if.bus_data_rd), 32'h00);
        rst = 1'b0;

        cpu_txn(1'b1, 1'b0, 16'h1234, 8'h00, 8'h5A, 0, 1'b0);
        cpu_txn(1'b0, 1'b1, 16'hFF00, 8'h03, 8'hC3, 0, 1'b0);
        cpu_txn(1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h77, 20, 1'b0);
        cpu_txn(1'b1, 1'b1, 16'h0010, 8'hEE, 8'h81, 0, 1'b0);

        // Abort a read after its third byte.
        @(negedge clk);
        rx5 = 8'h99;
        model_issue(1'b1, 16'h4321, 8'h00);
        bus_if.bus_read    = 1'b1;
        bus_if.bus_address = 16'h4321;
        base = mon_bytes;
        t = 0;
        while (mon_bytes < base + 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("abort_bytes_before_rst", 32'(mon_bytes - base), 32'd3);
        rst = 1'b1;
        bus_if.bus_read = 1'b0;
        exp_bytes.delete();
        exp_rd.delete();
        model_rd = 8'h00;
        @(posedge clk);
        #1;
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_byte_valid", 32'(byte_valid), 32'd0);
        check("abort_bus_done", 32'(bus_if.bus_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("txn %0d: READ  addr=4321 aborted by reset", ++txn_no);

        cpu_txn(1'b1, 1'b0, 16'h2468, 8'h00, 8'h3C, 0, 1'b0);
        for (int i = 0; i < 3; i++)
            cpu_txn(1'b1, 1'b0, 16'($urandom), 8'h00, 8'($urandom), 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            bit r, w;
            r = 1'($urandom);
            w = r ? 1'($urandom) : 1'b1;
            cpu_txn(r, w, 16'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (10) @(negedge clk);
        check("leftover_bytes", 32'(exp_bytes.size()), 32'd0);
        check("leftover_results", 32'(exp_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter CMD_READ, default 8'h03, SPI memory read opcode.
REQ-002 Parameter CMD_WRITE, default 8'h02, SPI memory write opcode.
REQ-003 Parameter ADDR_UPPER, default 8'h00, constant bits [23:16] of the 24-bit SPI address.
REQ-004 Parameter CS_GAP, default 2, spi_cs_n high cycles after each transaction (range 1..15).
REQ-005 Clocking and reset SHALL be exactly: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock, all logic on posedge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 bus_address  input  16  CPU bus address.
REQ-009 bus_data_wr  input  8  CPU write data.
REQ-010 bus_read  input  1  CPU read request, level.
REQ-011 bus_write  input  1  CPU write request, level.
REQ-012 bus_data_rd  output  8  read data returned to CPU.
REQ-013 bus_done  output  1  transaction complete; CPU wait = !bus_done.
REQ-014 spi_cs_n  output  1  SPI memory chip select, active-low.
REQ-015 byte_tx  output  8  byte to spi_core data_tx.
REQ-016 byte_valid  output  1  to spi_core have_data; byte_tx is valid.
REQ-017 byte_rx  input  8  from spi_core data_rx.
REQ-018 byte_done  input  1  from spi_core txn_done, one-cycle pulse per byte.

Function
REQ-019 FSM states SHALL be IDLE, CMD, ADDR_M, ADDR_L, DATA, GAP, ACK.
REQ-020 IDLE: on bus_read or bus_write high, latch address, write data and op type, drive spi_cs_n low, enter CMD next cycle.
REQ-021 Both bus_read and bus_write high in the same IDLE cycle SHALL be treated as a read.
REQ-022 CMD sends CMD_READ/CMD_WRITE; ADDR_M sends ADDR_UPPER; ADDR_L sends latched address[15:8]; DATA sends address[7:0]. A fifth byte then follows in the same DATA-phase handling: write data for writes, 8'h00 dummy for reads.
REQ-023 Byte sequence per transaction SHALL be exactly 5 bytes: opcode, ADDR_UPPER, addr[15:8], addr[7:0], data/dummy; a 3-bit byte counter selects the byte.
REQ-024 Byte handshake: byte_valid high with byte_tx stable until the byte_done pulse; byte_valid low for exactly 1 cycle after each byte_done, then the next byte is presented.
REQ-025 Read: byte_rx SHALL be captured into bus_data_rd on the byte_done of byte 5 only; bus_data_rd holds its value otherwise.
REQ-026 After byte 5 byte_done: byte_valid low, spi_cs_n high, enter GAP; GAP lasts CS_GAP cycles, then ACK.
REQ-027 ACK: bus_done high; held high until bus_read and bus_write are both low, then IDLE the following cycle with bus_done low.
REQ-028 A request held high through ACK SHALL NOT start a second transaction.
REQ-029 Request inputs changing after IDLE latch SHALL be ignored until ACK.
REQ-030 byte_done received while byte_valid is low SHALL be ignored.
REQ-031 spi_cs_n SHALL be low only in CMD through the byte 5 byte_done cycle.

Reset
REQ-032 On rst: state IDLE, spi_cs_n 1, byte_valid 0, byte_tx 8'h00, bus_done 0, bus_data_rd 8'h00, counters 0.
REQ-033 rst mid-transaction SHALL abort immediately: spi_cs_n high next edge, no bus_done pulse.

Structure
REQ-034 State encoding, CMD_READ/CMD_WRITE defaults and byte-count constant SHALL live in shared package soc_pkg.
REQ-035 No sub-module; the block is instantiated in soc between cpu and spi_core, replacing the fixed 8'hA5/have_data=1 tie-offs.

Verification
REQ-036 Read 16'h1234, SPI model returns 8'h5A on byte 5 -> MOSI bytes 03,00,12,34,00; bus_data_rd=8'h5A; bus_done high after CS_GAP cycles.
REQ-037 Write 16'hFF00 data 8'h03 -> MOSI bytes 02,00,FF,00,03; spi_cs_n low for entire 5 bytes; bus_data_rd unchanged.
REQ-038 bus_read held high 20 cycles past bus_done -> exactly one transaction (5 byte_done pulses); IDLE 1 cycle after request drops.
REQ-039 bus_read and bus_write asserted together at 16'h0010 -> read opcode 03 issued.
REQ-040 rst asserted after byte 3 -> spi_cs_n=1, byte_valid=0 next cycle; bus_done never asserted; next read completes normally.
REQ-041 Back-to-back reads -> spi_cs_n high for >= CS_GAP cycles between transactions.
